// File: rtl/exe_stage.sv
// Execute stage: operand-B select, single-cycle ALU, iterative unsigned mul/div
// with HI/LO, and the EXE/MEM output register.
module exe_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] ddpc4,
    input  logic [31:0] ddata1,
    input  logic [31:0] ddata2,
    input  logic [31:0] dext_imm,
    input  logic [4:0]  drw,
    input  logic [4:0]  naluop,
    input  logic        ns_b,
    input  logic        nreg_write,
    input  logic        nmem_write,
    input  logic [1:0]  ns_data_write,
    output logic        stall,
    output logic [31:0] ealu,
    output logic [31:0] edata2,
    output logic [31:0] epc4,
    output logic [4:0]  erw,
    output logic        ereg_write,
    output logic        emem_write,
    output logic        evalid,
    output logic [1:0]  es_data_write
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned CNTW = 5;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd13;
    localparam logic [4:0] OP_MFHI  = 5'd14;
    localparam logic [4:0] OP_MFLO  = 5'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   wh_q, wh_d;
    logic [XLEN-1:0]   wl_q, wl_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic [XLEN-1:0]   ealu_q, ealu_d;
    logic [XLEN-1:0]   edata2_q, edata2_d;
    logic [XLEN-1:0]   epc4_q, epc4_d;
    logic [RW-1:0]     erw_q, erw_d;
    logic              ereg_write_q, ereg_write_d;
    logic              emem_write_q, emem_write_d;
    logic              evalid_q, evalid_d;
    logic [1:0]        es_data_write_q, es_data_write_d;

    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_res;
    logic              is_muldiv;
    logic              start;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;

    assign op_b      = ns_b ? dext_imm : ddata2;
    assign is_muldiv = (naluop == OP_MULTU) || (naluop == OP_DIVU);
    assign start     = (state_q == ST_IDLE) && in_valid && is_muldiv;
    assign stall     = start || (state_q == ST_BUSY);

    // Multiply: {wh,wl} holds partial product in the top and unconsumed multiplier bits below.
    assign mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
    // Divide: wh is the running remainder, wl shifts dividend out and quotient in.
    assign rem_shift = {wh_q, wl_q[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, opb_q};

    always_comb begin
        alu_res = '0;
        case (naluop)
            OP_ADD:  alu_res = ddata1 + op_b;
            OP_SUB:  alu_res = ddata1 - op_b;
            OP_AND:  alu_res = ddata1 & op_b;
            OP_OR:   alu_res = ddata1 | op_b;
            OP_XOR:  alu_res = ddata1 ^ op_b;
            OP_NOR:  alu_res = ~(ddata1 | op_b);
            OP_SLT:  alu_res = XLEN'($signed(ddata1) < $signed(op_b));
            OP_SLTU: alu_res = XLEN'(ddata1 < op_b);
            OP_SLL:  alu_res = op_b << ddata1[4:0];
            OP_SRL:  alu_res = op_b >> ddata1[4:0];
            OP_SRA:  alu_res = XLEN'($signed(op_b) >>> ddata1[4:0]);
            OP_LUI:  alu_res = {op_b[15:0], 16'h0000};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Mul/div sequencer: IDLE loads, BUSY runs 32 steps, DONE commits HI/LO.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opb_d    = opb_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    is_div_d = (naluop == OP_DIVU);
                    opb_d    = op_b;
                    wh_d     = '0;
                    wl_d     = ddata1;
                end
            end
            ST_BUSY: begin
                if (is_div_q) begin
                    if (!div_diff[XLEN]) begin
                        wh_d = div_diff[XLEN-1:0];
                        wl_d = {wl_q[XLEN-2:0], 1'b1};
                    end else begin
                        wh_d = rem_shift[XLEN-1:0];
                        wl_d = {wl_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    wh_d = mul_sum[XLEN:1];
                    wl_d = {mul_sum[0], wl_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(31)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d    = wh_q;
                lo_d    = wl_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // EXE/MEM register input: bubble while stalled.
    always_comb begin
        ealu_d          = '0;
        edata2_d        = '0;
        epc4_d          = '0;
        erw_d           = '0;
        ereg_write_d    = 1'b0;
        emem_write_d    = 1'b0;
        evalid_d        = 1'b0;
        es_data_write_d = '0;
        if (!stall) begin
            ealu_d          = alu_res;
            edata2_d        = ddata2;
            epc4_d          = ddpc4;
            erw_d           = drw;
            ereg_write_d    = nreg_write & in_valid;
            emem_write_d    = nmem_write & in_valid;
            evalid_d        = in_valid;
            es_data_write_d = ns_data_write;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            is_div_q        <= 1'b0;
            opb_q           <= '0;
            wh_q            <= '0;
            wl_q            <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            ealu_q          <= '0;
            edata2_q        <= '0;
            epc4_q          <= '0;
            erw_q           <= '0;
            ereg_write_q    <= 1'b0;
            emem_write_q    <= 1'b0;
            evalid_q        <= 1'b0;
            es_data_write_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_div_q        <= is_div_d;
            opb_q           <= opb_d;
            wh_q            <= wh_d;
            wl_q            <= wl_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            ealu_q          <= ealu_d;
            edata2_q        <= edata2_d;
            epc4_q          <= epc4_d;
            erw_q           <= erw_d;
            ereg_write_q    <= ereg_write_d;
            emem_write_q    <= emem_write_d;
            evalid_q        <= evalid_d;
            es_data_write_q <= es_data_write_d;
        end
    end

    assign ealu          = ealu_q;
    assign edata2        = edata2_q;
    assign epc4          = epc4_q;
    assign erw           = erw_q;
    assign ereg_write    = ereg_write_q;
    assign emem_write    = emem_write_q;
    assign evalid        = evalid_q;
    assign es_data_write = es_data_write_q;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipeline, placed directly downstream of the ID/EXE pipeline register and upstream of the MEM stage. It consumes the decoded operands and control bits and selects the second ALU operand. Single-cycle ALU ops complete in one cycle. Unsigned multiply/divide run on an iterative 32-step unit that stalls the front of the pipeline. Results are registered into EXE/MEM outputs.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- `clock` in 1: single clock; all flops on rising edge.
- `reset` in 1: asynchronous, active-low; clears every flop immediately.
- `in_valid` in 1: the ID/EXE register holds a real instruction; 0 means a bubble.
- `ddpc4` in 32: PC+4 of the instruction.
- `ddata1` in 32: operand A (rs).
- `ddata2` in 32: rt value; also the store data.
- `dext_imm` in 32: extended immediate.
- `drw` in 5: destination register.
- `naluop` in 5: operation code, see Operation.
- `ns_b` in 1: 1 selects `dext_imm` as operand B, 0 selects `ddata2`.
- `nreg_write` in 1: register write enable, passed through.
- `nmem_write` in 1: memory write enable, passed through.
- `ns_data_write` in 2: write-back source select, passed through.
- `stall` out 1: combinational; upstream stages and ID/EXE hold while it is 1.
- `ealu`, `edata2`, `epc4` out 32: registered ALU result, store data and PC+4.
- `erw` out 5: registered destination register.
- `ereg_write`, `emem_write`, `evalid` out 1: registered control bits.
- `es_data_write` out 2: registered write-back select.

## Operation
- Operand B = `ns_b` ? `dext_imm` : `ddata2`. All arithmetic is modulo 2^32; overflow is ignored.
- `naluop` codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: B shifted by A[4:0].
  - 11 LUI: B<<16.
  - 12 MULTU, 13 DIVU.
  - 14 MFHI, 15 MFLO.
  - Codes 16-31 produce result 0.
- Internal 32-bit HI and LO registers:
  - MULTU writes {HI,LO} = A*B, full unsigned 64-bit product via 32 shift-add steps.
  - DIVU writes LO = A/B and HI = A%B via 32 restoring steps.
  - Divide by zero gives LO = 0xFFFFFFFF and HI = A, the natural restoring result; no exception.
- MULTU/DIVU place 0 on `ealu`; their write enables pass through as given by decode, which sets them to 0.
- FSM states:
  - IDLE: a muldiv op with `in_valid`=1 loads the operands, clears the step count and moves to BUSY. All other ops pass straight through.
  - BUSY: one step per cycle. After the 32nd step it moves to DONE.
  - DONE: HI/LO are written at the closing edge; the FSM returns to IDLE.
- `stall` = (IDLE and `in_valid` and op is 12/13) or BUSY. It is 0 in DONE.
- EXE/MEM load rules:
  - While `stall`=1 the outputs load a bubble: `evalid`, `ereg_write` and `emem_write` = 0; other outputs are don't-care, driven to 0.
  - Otherwise all outputs load from the current instruction, and `evalid` = `in_valid`.
  - When `in_valid`=0, `ereg_write` = `emem_write` = 0.
- `in_valid`=0 with a muldiv code does not start the unit.

## Timing
- Reset (`reset`=0) values:
  - All registered outputs 0; HI = LO = 0; FSM in IDLE.
  - `stall` therefore evaluates combinationally from the inputs.
- Reset asserted mid-operation aborts the operation; HI/LO become 0 and the step count is lost.
- Single-cycle op presented in cycle t: outputs valid after the edge ending cycle t (latency 1).
- MULTU/DIVU presented in cycle t:
  - `stall`=1 in cycles t..t+32 (33 cycles) and 0 in cycle t+33 (DONE).
  - The EXE/MEM outputs capture the op, and HI/LO update, at the edge ending cycle t+33.
  - The FSM is back in IDLE in cycle t+34.
- MFHI/MFLO directly following a muldiv enters at cycle t+34 and reads the updated HI/LO; no forwarding is needed.
- Back-to-back muldivs: the second one enters IDLE at t+34 and stalls again.

## Test plan
- ADD: `ddata1`=5, `dext_imm`=7, `ns_b`=1, `nreg_write`=1, `drw`=3 -> next cycle `ealu`=12, `erw`=3, `ereg_write`=1, `evalid`=1; `stall` never 1.
- SUB and SLT: SUB with A=0, B=1 -> `ealu`=0xFFFFFFFF. SLT with A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0.
- MULTU then MFHI/MFLO:
  - A=0xFFFFFFFF, B=2 -> `stall` high exactly 33 cycles, with bubbles (`evalid`=0) loaded during the stall.
  - Following MFHI -> `ealu`=1; then MFLO -> `ealu`=0xFFFFFFFE.
- DIVU: A=100, B=7 -> MFLO gives 14, MFHI gives 2. Divide by zero with A=9, B=0 -> LO=0xFFFFFFFF, HI=9.
- Reset during BUSY: assert `reset`=0 at step 10 -> outputs 0 immediately, HI/LO 0. After release with `in_valid`=0 -> `stall`=0 and the FSM is in IDLE.
- Bubble input: `in_valid`=0 with `naluop`=12 and `nreg_write`=1 -> no stall, `evalid`=0, `ereg_write`=0.
